// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - PC sequencer, imem handshake, IR and opcode/immediate decode
module instr_fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic        dec_valid,
    output logic [15:0] dec_pc,
    output logic [3:0]  dec_opcode,
    output logic [11:0] dec_field,
    output logic [1:0]  dec_ext_sel,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;

    // Fetch sequencer: branch redirect outranks both the memory ack and the stall hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            ir          <= 16'h0000;
            dec_pc      <= 16'h0000;
            fetch_count <= 16'h0000;
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (branch_valid) begin
                        // Returned data (if any) belongs to the abandoned path
                        pc <= branch_target;
                    end else if (imem_ack) begin
                        ir     <= imem_rdata;
                        dec_pc <= pc;
                        pc     <= pc + PC_STEP;
                        state  <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (branch_valid) begin
                        pc    <= branch_target;
                        state <= S_FETCH;
                        // A stalled instruction is squashed, so it is not counted
                        if (!stall) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                    end else if (!stall) begin
                        fetch_count <= fetch_count + 16'd1;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

    // Handshake outputs come from registered state only, so reset drops them asynchronously
    assign imem_req   = (state == S_FETCH);
    assign dec_valid  = (state == S_VALID);
    assign imem_addr  = pc;
    assign dec_opcode = ir[15:12];
    assign dec_field  = ir[11:0];

    // Extend-select for the sign-extension stage, chosen by opcode group
    always_comb begin
        dec_ext_sel = 2'b10;
        case (ir[15:12])
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: dec_ext_sel = 2'b10;
            4'h8, 4'h9, 4'hA, 4'hB: dec_ext_sel = 2'b01;
            4'hC:                   dec_ext_sel = 2'b11;
            default:                dec_ext_sel = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        stall;
    logic        dec_valid;
    logic [15:0] dec_pc;
    logic [3:0]  dec_opcode;
    logic [11:0] dec_field;
    logic [1:0]  dec_ext_sel;
    logic [15:0] fetch_count;

    instr_fetch_decode #(.RESET_PC(RST_PC), .PC_STEP(16'd2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
        .dec_valid     (dec_valid),
        .dec_pc        (dec_pc),
        .dec_opcode    (dec_opcode),
        .dec_field     (dec_field),
        .dec_ext_sel   (dec_ext_sel),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } item_t;

    item_t       q[$];
    item_t       cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_pc;
    logic [15:0] exp_count;
    bit          pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_ext(input logic [15:0] data);
        int op;
        op = int'(data >> 12);
        if (op < 8)       return 2'b10;
        else if (op < 12) return 2'b01;
        else if (op == 12) return 2'b11;
        else              return 2'b00;
    endfunction

    // One stimulus cycle: drive at negedge and record what the memory side expects
    task automatic cycle(input bit ack, input logic [15:0] data, input bit st,
                         input bit br, input logic [15:0] tgt);
        bit b_eff;
        @(negedge clk);
        b_eff = br && (imem_req || (dec_valid && st));
        if (imem_req) begin
            chk("imem_addr", imem_addr, exp_pc);
            if (b_eff) begin
                exp_pc = tgt;
            end else if (ack) begin
                q.push_back('{exp_pc, data});
                exp_pc = exp_pc + 16'd2;
                pend   = 1'b1;
            end
        end else if (b_eff) begin
            exp_pc = tgt;
        end
        imem_ack      = ack;
        imem_rdata    = data;
        stall         = st;
        branch_valid  = b_eff;
        branch_target = tgt;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   imem_req, 0);
        chk({tag, "_addr"},  imem_addr, RST_PC);
        chk({tag, "_valid"}, dec_valid, 0);
        chk({tag, "_pc"},    dec_pc, 0);
        chk({tag, "_op"},    dec_opcode, 0);
        chk({tag, "_field"}, dec_field, 0);
        chk({tag, "_ext"},   dec_ext_sel, 2'b10);
        chk({tag, "_count"}, fetch_count, 0);
    endtask

    // Monitor: samples just after each rising edge, pops on each new delivery
    initial begin
        bit v, s, b, p, rising;
        bit prev_v;
        prev_v    = 1'b0;
        exp_count = 16'h0000;
        forever begin
            @(posedge clk);
            v = dec_valid;
            s = stall;
            b = branch_valid;
            p = pend;
            pend = 1'b0;
            #1;
            if (!rst_n) begin
                prev_v    = 1'b0;
                exp_count = 16'h0000;
                continue;
            end
            if (v && !s && !b) exp_count = exp_count + 16'd1;
            chk("fetch_count", fetch_count, exp_count);
            rising = dec_valid && !prev_v;
            chk("valid_timing", rising, p);
            if (rising) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: dec_valid rose with nothing expected at %0t", $time);
                end else begin
                    cur = q.pop_front();
                end
            end
            if (dec_valid) begin
                chk("dec_pc",      dec_pc, cur.pc);
                chk("dec_opcode",  dec_opcode, cur.data >> 12);
                chk("dec_field",   dec_field, cur.data & 16'h0FFF);
                chk("dec_ext_sel", dec_ext_sel, ref_ext(cur.data));
            end
            chk("req_vs_valid", imem_req && dec_valid, 0);
            prev_v = dec_valid;
        end
    end

    initial begin
        logic [15:0] d;
        logic [15:0] t;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        branch_valid = 1'b0;
        branch_target = 16'h0000;
        stall = 1'b0;
        pend = 1'b0;
        exp_pc = RST_PC;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Zero-wait fetch of 8A5F at the reset PC, next request at 0102
        cycle(1, 16'h8A5F, 0, 0, 0);
        chk("first_req", imem_req, 1);
        cycle(0, 0, 0, 0, 0);
        chk("first_valid", dec_valid, 1);

        // Three wait cycles before ack, then a 5-cycle stall
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 16'h3456, 0, 0, 0);
        repeat (5) cycle(0, 0, 1, 0, 0);
        chk("stall_no_req", imem_req, 0);
        cycle(0, 0, 0, 0, 0);

        // Branch coinciding with ack discards the returned word
        cycle(1, 16'hD123, 0, 1, 16'h2000);
        cycle(0, 0, 0, 0, 0);
        chk("branch_addr", imem_addr, 16'h2000);

        // Opcode sweep through memory
        for (int op = 0; op < 16; op++) begin
            d = 16'($urandom);
            d[15:12] = op[3:0];
            cycle(1, d, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end

        // PC wrap from FFFE
        cycle(0, 0, 0, 1, 16'hFFFE);
        cycle(1, 16'hC0DE, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("pc_wrap", imem_addr, 16'h0000);

        // fetch_count wrap after preload
        force dut.fetch_count = 16'hFFFF;
        exp_count = 16'hFFFF;
        cycle(0, 0, 0, 0, 0);
        release dut.fetch_count;
        cycle(1, 16'h1111, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("count_wrap", fetch_count, 16'h0000);

        // Reset mid-fetch, with a late ack held across release
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        pend = 1'b0;
        exp_pc = RST_PC;
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);
        chk("resume_req", imem_req, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            t = 16'($urandom) & 16'hFFFE;
            cycle(($urandom % 2) == 0, 16'($urandom), ($urandom % 3) == 0,
                  ($urandom % 10) == 0, t);
        end

        repeat (4) cycle(0, 0, 0, 0, 0);
        chk("sb_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
